// File: rtl/led_pattern_sequencer_if.sv
// rtl/led_pattern_sequencer_if.sv - button/run/LED signal bundle for led_pattern_sequencer
//
// Signals:
//   btn   push-button, active-low (0 = pressed), asynchronous to clk
//   run   1 = pattern advances on each tick, 0 = pattern frozen
//   led   LED drive, 1 = lit
//   mode  current pattern mode (0 ROT_R, 1 ROT_L, 2 BOUNCE, 3 FILL)
//   tick  one-cycle pulse per pattern step
// Modports:
//   master  board side: drives btn/run, observes led/mode/tick
//   slave   sequencer side
interface led_pattern_sequencer_if #(
    parameter int LEDS_NR = 6
);
    logic               btn;
    logic               run;
    logic [LEDS_NR-1:0] led;
    logic [1:0]         mode;
    logic               tick;

    modport master (output btn, output run, input led, input mode, input tick);
    modport slave  (input btn, input run, output led, output mode, output tick);
endinterface

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - LED pattern sequencer: tick prescaler, button debounce, mode FSM
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   asynchronous active-low reset
//   bus   led_pattern_sequencer_if.slave (btn, run in; led, mode, tick out)
// Optional build macro:
//   SEQ_PWM_EN  when defined, led is gated by an 8-bit free-running PWM counter
//               (on for PWM_DUTY of every 256 cycles, one cycle behind pwm_cnt)
module led_pattern_sequencer #(
    parameter int LEDS_NR    = 6,
    parameter int TICK_DIV   = 12_000_000,
    parameter int DEB_CYCLES = 120_000,
    parameter int PWM_DUTY   = 64
) (
    input logic                    clk,
    input logic                    rst,
    led_pattern_sequencer_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        ROT_R  = 2'd0,
        ROT_L  = 2'd1,
        BOUNCE = 2'd2,
        FILL   = 2'd3
    } mode_t;

    // Prescaler: tick_r is high exactly while pre_cnt is 0, registered
    // one cycle early so tick itself has no decode logic in front of it.
    logic [PW-1:0] pre_cnt;
    logic          tick_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= PW'(TICK_DIV - 1);
            tick_r  <= 1'b0;
        end else begin
            if (pre_cnt == '0) begin
                pre_cnt <= PW'(TICK_DIV - 1);
            end else begin
                pre_cnt <= pre_cnt - 1'b1;
            end
            tick_r <= (pre_cnt == PW'(1));
        end
    end

    // Button: two-flop synchronizer followed by a stability counter.
    logic          sync1;
    logic          sync2;
    logic          deb;
    logic [DW-1:0] deb_cnt;
    logic          accept;
    logic          press;

    // accept fires on the DEB_CYCLES-th consecutive differing sample.
    assign accept = (sync2 != deb) && (deb_cnt == DW'(DEB_CYCLES - 1));
    assign press  = accept && !sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_cnt <= '0;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (accept) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Mode FSM and pattern register. A press wins over a coincident tick.
    mode_t              mode_r;
    logic [LEDS_NR-1:0] pattern;
    logic               dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r  <= ROT_R;
            pattern <= LEDS_NR'(1);
            dir     <= 1'b0;
        end else if (press) begin
            dir <= 1'b0;
            case (mode_r)
                ROT_R:   begin mode_r <= ROT_L;  pattern <= LEDS_NR'(1); end
                ROT_L:   begin mode_r <= BOUNCE; pattern <= LEDS_NR'(1); end
                BOUNCE:  begin mode_r <= FILL;   pattern <= '0;          end
                default: begin mode_r <= ROT_R;  pattern <= LEDS_NR'(1); end
            endcase
        end else if (tick_r && bus.run) begin
            case (mode_r)
                ROT_R: pattern <= {pattern[0], pattern[LEDS_NR-1:1]};
                ROT_L: pattern <= {pattern[LEDS_NR-2:0], pattern[LEDS_NR-1]};
                BOUNCE: begin
                    // Turn around on reaching an end so each end shows for one tick.
                    if (!dir && pattern[LEDS_NR-1]) begin
                        dir     <= 1'b1;
                        pattern <= pattern >> 1;
                    end else if (dir && pattern[0]) begin
                        dir     <= 1'b0;
                        pattern <= pattern << 1;
                    end else if (!dir) begin
                        pattern <= pattern << 1;
                    end else begin
                        pattern <= pattern >> 1;
                    end
                end
                default: begin
                    if (&pattern) begin
                        pattern <= '0;
                    end else begin
                        pattern <= {pattern[LEDS_NR-2:0], 1'b1};
                    end
                end
            endcase
        end
    end

`ifdef SEQ_PWM_EN
    logic [7:0]         pwm_cnt;
    logic [LEDS_NR-1:0] led_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= 8'd0;
            led_r   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            led_r   <= pattern & {LEDS_NR{({1'b0, pwm_cnt} < 9'(PWM_DUTY))}};
        end
    end

    assign bus.led = led_r;
`else
    assign bus.led = pattern;
`endif

    assign bus.mode = mode_r;
    assign bus.tick = tick_r;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - self-checking bench for led_pattern_sequencer
module tb_led_pattern_sequencer;
    localparam int N = 4;
    localparam int T = 4;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_pattern_sequencer_if #(.LEDS_NR(N)) bus ();

    led_pattern_sequencer #(
        .LEDS_NR(N), .TICK_DIV(T), .DEB_CYCLES(D), .PWM_DUTY(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: edges since reset release, current mode, and the
    // number of steps taken in that mode; the LED pattern is a closed-form
    // function of (mode, steps).
    int e;
    int m_mode;
    int m_k;
    bit m_deb;
    bit bq[$];
    bit sq[$];

    function automatic logic [N-1:0] exp_pat(input int md, input int k);
        logic [N-1:0] p;
        int pos;
        int idx;
        p = '0;
        case (md)
            0: p[(N - (k % N)) % N] = 1'b1;
            1: p[k % N] = 1'b1;
            2: begin
                pos = k % (2 * N - 2);
                idx = (pos < N) ? pos : (2 * N - 2 - pos);
                p[idx] = 1'b1;
            end
            default: for (int i = 0; i < (k % (N + 1)); i++) p[i] = 1'b1;
        endcase
        return p;
    endfunction

    task automatic model_reset();
        e = 0;
        m_mode = 0;
        m_k = 0;
        m_deb = 1'b1;
        bq.delete();
        sq.delete();
        repeat (2) bq.push_back(1'b1);
        repeat (D) sq.push_back(1'b1);
    endtask

    // btn reaches the debouncer two edges after being sampled; a level is
    // accepted once the last D samples all disagree with the debounced level.
    task automatic model_edge(input bit b, input bit r);
        bit s;
        bit acc;
        bit press;
        e++;
        s = bq.pop_front();
        bq.push_back(b);
        void'(sq.pop_front());
        sq.push_back(s);
        acc = 1'b1;
        foreach (sq[i]) if (sq[i] == m_deb) acc = 1'b0;
        if (acc) m_deb = s;
        press = acc && !s;
        if (press) begin
            m_mode = (m_mode + 1) % 4;
            m_k = 0;
        end else if ((e % T == 0) && r) begin
            m_k++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] el;
        logic [1:0]   em;
        logic         et;
        el = exp_pat(m_mode, m_k);
        em = 2'(m_mode);
        et = ((e + 1) % T == 0);
        checks++;
        assert (bus.led === el) else begin
            errors++;
            $error("FAIL %s led: got %b expected %b (edge %0d)", tag, bus.led, el, e);
        end
        checks++;
        assert (bus.mode === em) else begin
            errors++;
            $error("FAIL %s mode: got %0d expected %0d (edge %0d)", tag, bus.mode, em, e);
        end
        checks++;
        assert (bus.tick === et) else begin
            errors++;
            $error("FAIL %s tick: got %b expected %b (edge %0d)", tag, bus.tick, et, e);
        end
    endtask

    task automatic cyc(input bit b, input bit r, input string tag);
        bus.btn = b;
        bus.run = r;
        @(posedge clk);
        model_edge(b, r);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic press_btn(input string tag);
        repeat (6) cyc(1'b0, 1'b1, tag);
        repeat (8) cyc(1'b1, 1'b1, tag);
    endtask

    initial begin
        int len;
        bit b;
        bit r;
        bus.btn = 1'b1;
        bus.run = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;

        repeat (17) cyc(1'b1, 1'b1, "rot_r");

        repeat (6) cyc(1'b0, 1'b1, "press_hold");
        repeat (18) cyc(1'b1, 1'b1, "rot_l");
        repeat (2) cyc(1'b0, 1'b1, "glitch");
        repeat (8) cyc(1'b1, 1'b1, "glitch_after");

        press_btn("to_bounce");
        repeat (32) cyc(1'b1, 1'b1, "bounce");
        press_btn("to_fill");
        repeat (24) cyc(1'b1, 1'b1, "fill");
        press_btn("to_rot_r");

        repeat (14) cyc(1'b1, 1'b0, "run_off");

        // Press lands four edges after btn is first sampled low: align to a tick edge.
        for (int i = 0; i < T && ((e + 1) % T != 0); i++) cyc(1'b1, 1'b1, "align");
        repeat (6) cyc(1'b0, 1'b1, "press_on_tick");
        repeat (10) cyc(1'b1, 1'b1, "after_tick_press");

        press_btn("to_bounce2");
        for (int i = 0; i < 40 && (m_k % (2 * N - 2)) != N; i++) cyc(1'b1, 1'b1, "bounce_dir1");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (10) cyc(1'b1, 1'b1, "after_reset");

        for (int n = 0; n < 60; n++) begin
            len = $urandom_range(1, 6);
            b = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 3) != 0);
            repeat (len) cyc(b, r, "random");
        end
        repeat (8) cyc(1'b1, 1'b1, "tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
